dat_write_feeder: RTL and testbench

DAT_WRITE_FEEDER -- requirements
Module: dat_write_feeder

---
 rtl/sdhci_pkg.sv | 9 +
 rtl/dat_write_fifo.sv | 43 ++++
 rtl/dat_write_feeder.sv | 127 ++++++++++++
 tb/tb_dat_write_feeder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdhci_pkg.sv
// sdhci_pkg: shared write-feeder state encoding and FIFO sizing helpers
package sdhci_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, START, SEND, FLUSH} wr_state_e;
  localparam int unsigned DefaultMaxBlockBitSize = 10;
  localparam int unsigned FifoDepth = 2 ** (DefaultMaxBlockBitSize - 2);
  function automatic int unsigned fifo_depth(input int unsigned block_bits);
    return 2 ** (block_bits - 2);
  endfunction
endpackage

// File: rtl/dat_write_fifo.sv
// dat_write_fifo: show-ahead 32-bit FIFO with fill count and one-cycle flush
// Ports: clk_i/rst_i (async high), flush_i empties, push_i/data_i write,
// pop_i advances head, data_o head word (0 when empty), full_o/empty_o/count_o status.
module dat_write_fifo #(
  parameter int unsigned AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [31:0]   data_i,
  input  logic          pop_i,
  output logic [31:0]   data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  logic [31:0] mem [2**AW];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  // count never exceeds 2^AW, so its top bit alone marks full
  assign full_o = cnt_q[AW];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop = pop_i && !empty_o && !flush_i;
  assign data_o = empty_o ? '0 : mem[rd_q];
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= data_i;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/dat_write_feeder.sv
// dat_write_feeder: buffers host write words and paces blocks into the SD write serializer
// Ports: clk_i/rst_i (async high), sd_clk_en_p_i SD edge enable, start_i/stop_i control,
// block_size_i/block_count_i/block_count_en_i transfer setup, wr_* host write side,
// buf_wr_en_o room for a block, dat_* serializer side, xfer_done_o/xfer_err_o end pulses,
// blocks_done_o completed block count.
module dat_write_feeder
  import sdhci_pkg::*;
#(
  parameter int unsigned MaxBlockBitSize = DefaultMaxBlockBitSize
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sd_clk_en_p_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [15:0]                block_count_i,
  input  logic                       block_count_en_i,
  input  logic [31:0]                wr_data_i,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  output logic                       buf_wr_en_o,
  output logic                       dat_start_o,
  output logic [31:0]                dat_data_o,
  input  logic                       dat_next_word_i,
  input  logic                       dat_done_i,
  input  logic                       dat_crc_err_i,
  input  logic                       dat_timeout_i,
  input  logic                       dat_end_bit_err_i,
  output logic                       xfer_done_o,
  output logic                       xfer_err_o,
  output logic [15:0]                blocks_done_o
);
  localparam int unsigned AW = MaxBlockBitSize - 2;
  localparam int unsigned Depth = fifo_depth(MaxBlockBitSize);
  wr_state_e state_q, state_d;
  logic [15:0] rem_q, rem_d, done_q, done_d;
  logic [AW:0] wpb_q, wpb_d, count, wpb_new;
  logic cnt_en_q, cnt_en_d, stop_q, stop_d, under_q, under_d;
  logic full, empty, err;
  assign wpb_new = (AW+1)'((32'(block_size_i) + 32'd3) >> 2);
  assign wr_ready_o = !full && state_q != FLUSH;
  assign buf_wr_en_o = (AW+1)'(Depth) - count >= wpb_q;
  assign blocks_done_o = done_q;
  assign err = dat_crc_err_i || dat_timeout_i || dat_end_bit_err_i || under_q;
  dat_write_fifo #(.AW(AW)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (state_q == FLUSH),
    .push_i  (wr_valid_i && wr_ready_o),
    .data_i  (wr_data_i),
    .pop_i   (dat_next_word_i),
    .data_o  (dat_data_o),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    done_d = done_q;
    wpb_d = wpb_q;
    cnt_en_d = cnt_en_q;
    stop_d = stop_q;
    under_d = under_q || (dat_next_word_i && empty);
    dat_start_o = 1'b0;
    xfer_done_o = 1'b0;
    xfer_err_o = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = WAIT_DATA;
        // a zero count in finite mode still moves one block
        rem_d = block_count_i == '0 ? 16'd1 : block_count_i;
        done_d = '0;
        under_d = 1'b0;
        stop_d = 1'b0;
        wpb_d = wpb_new;
        cnt_en_d = block_count_en_i;
      end
      WAIT_DATA: begin
        xfer_done_o = stop_i;
        state_d = stop_i ? IDLE : count >= wpb_q ? START : WAIT_DATA;
      end
      START: begin
        dat_start_o = 1'b1;
        stop_d = stop_q || stop_i;
        state_d = sd_clk_en_p_i ? SEND : START;
      end
      SEND: begin
        stop_d = stop_q || stop_i;
        if (dat_done_i && err) begin
          xfer_err_o = 1'b1;
          state_d = FLUSH;
        end else if (dat_done_i) begin
          done_d = done_q + 16'(done_q != 16'hFFFF);
          if ((cnt_en_q && rem_q == 16'd1) || stop_q || stop_i) begin
            xfer_done_o = 1'b1;
            state_d = IDLE;
          end else begin
            rem_d = rem_q - 16'd1;
            state_d = WAIT_DATA;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q <= '0;
      done_q <= '0;
      wpb_q <= '0;
      cnt_en_q <= 1'b0;
      stop_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      done_q <= done_d;
      wpb_q <= wpb_d;
      cnt_en_q <= cnt_en_d;
      stop_q <= stop_d;
      under_q <= under_d;
    end
  end
endmodule

// File: tb/tb_dat_write_feeder.sv
// tb_dat_write_feeder: directed scoreboard bench for dat_write_feeder
module tb_dat_write_feeder;
  import sdhci_pkg::*;
  logic clk = 0, rst = 1, sd_en = 1, start = 0, stop = 0, bce = 0;
  logic [9:0] bs = '0;
  logic [15:0] bc = '0;
  logic [31:0] wdata = '0;
  logic wvalid = 0, nxt = 0, ddone = 0, crc = 0, tmo = 0, ebe = 0;
  logic wready, bufen, dstart, xdone, xerr;
  logic [31:0] ddata;
  logic [15:0] bdone;
  int checks = 0, errors = 0;
  logic [31:0] exp_data[$];
  logic [16:0] exp_evt[$];
  logic [16:0] pend;
  logic pend_v = 0;
  logic [31:0] seq = 0;

  dat_write_feeder dut (
    .clk_i(clk), .rst_i(rst), .sd_clk_en_p_i(sd_en), .start_i(start), .stop_i(stop),
    .block_size_i(bs), .block_count_i(bc), .block_count_en_i(bce),
    .wr_data_i(wdata), .wr_valid_i(wvalid), .wr_ready_o(wready), .buf_wr_en_o(bufen),
    .dat_start_o(dstart), .dat_data_o(ddata), .dat_next_word_i(nxt), .dat_done_i(ddone),
    .dat_crc_err_i(crc), .dat_timeout_i(tmo), .dat_end_bit_err_i(ebe),
    .xfer_done_o(xdone), .xfer_err_o(xerr), .blocks_done_o(bdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      wdata = 32'hA500_0000 + seq;
      exp_data.push_back(wdata);
      seq++;
      wvalid = 1;
      tick();
    end
    wvalid = 0;
  endtask

  task automatic pop_n(input int n);
    nxt = 1;
    repeat (n) tick();
    nxt = 0;
  endtask

  task automatic go(input logic [9:0] b, input logic [15:0] c, input logic e);
    bs = b;
    bc = c;
    bce = e;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic done_pulse(input logic e);
    crc = e;
    ddone = 1;
    tick();
    ddone = 0;
    crc = 0;
  endtask

  task automatic wait_start(input string name);
    logic seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = dstart;
    end
    chk(name, 32'(seen), 1);
    tick();
  endtask

  always @(negedge clk) begin
    if (pend_v) begin
      chk("blocks_done", 32'(bdone), 32'(pend[15:0]));
      pend_v = 0;
    end
    if (nxt && !rst) begin
      if (exp_data.size() > 0) chk("pop_data", ddata, exp_data.pop_front());
      else chk("pop_empty_data", ddata, 0);
    end
    if (xdone || xerr) begin
      if (exp_evt.size() == 0) chk("unexpected_event", {30'd0, xerr, xdone}, 0);
      else begin
        pend = exp_evt.pop_front();
        chk("xfer_err", 32'(xerr), 32'(pend[16]));
        chk("xfer_done", 32'(xdone), 32'(!pend[16]));
        pend_v = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("rst_wr_ready", 32'(wready), 1);
    chk("rst_buf_wr_en", 32'(bufen), 1);
    chk("rst_dat_start", 32'(dstart), 0);
    chk("rst_dat_data", ddata, 0);
    chk("rst_done_err", {30'd0, xdone, xerr}, 0);
    chk("rst_blocks_done", 32'(bdone), 0);
    rst = 0;
    tick();
    // single block with held start until the SD edge enable arrives
    sd_en = 0;
    write_n(128);
    go(10'd512, 16'd1, 1);
    wait_start("single_start");
    repeat (3) @(negedge clk);
    chk("start_held", 32'(dstart), 1);
    sd_en = 1;
    tick();
    chk("send_start_low", 32'(dstart), 0);
    pop_n(128);
    exp_evt.push_back({1'b0, 16'd1});
    done_pulse(0);
    repeat (2) tick();
    chk("single_count", 32'(dut.u_fifo.count_o), 0);
    // starvation; a second start while busy must be ignored
    go(10'd512, 16'd2, 1);
    write_n(100);
    repeat (3) tick();
    chk("starve_100", 32'(dstart), 0);
    go(10'd8, 16'd1, 1);
    write_n(27);
    repeat (2) tick();
    chk("starve_127", 32'(dstart), 0);
    write_n(1);
    wait_start("start_after_128");
    pop_n(128);
    done_pulse(0);
    tick();
    exp_evt.push_back({1'b0, 16'd1});
    stop = 1;
    tick();
    stop = 0;
    repeat (2) tick();
    chk("stop_wait_idle", 32'(dut.state_q), 32'(IDLE));
    // crc error in block 1 of 3 flushes leftovers
    write_n(148);
    go(10'd512, 16'd3, 1);
    wait_start("err_start");
    pop_n(128);
    exp_evt.push_back({1'b1, 16'd0});
    done_pulse(1);
    @(negedge clk);
    chk("flush_wr_ready", 32'(wready), 0);
    tick();
    chk("flush_count", 32'(dut.u_fifo.count_o), 0);
    chk("flush_blocks_done", 32'(bdone), 0);
    exp_data.delete();
    // infinite mode, stop during block 5
    go(10'd8, 16'd0, 0);
    for (int b = 1; b <= 5; b++) begin
      write_n(2);
      wait_start("inf_start");
      pop_n(2);
      if (b == 5) begin
        exp_evt.push_back({1'b0, 16'd5});
        stop = 1;
        tick();
        stop = 0;
        tick();
        chk("inf_stop_waits", 32'(xdone), 0);
      end
      done_pulse(0);
      tick();
    end
    // full FIFO: simultaneous write is dropped while the pop proceeds
    write_n(FifoDepth);
    chk("full_wr_ready", 32'(wready), 0);
    chk("full_buf_wr_en", 32'(bufen), 0);
    wdata = 32'hDEAD_BEEF;
    wvalid = 1;
    nxt = 1;
    tick();
    wvalid = 0;
    nxt = 0;
    chk("full_drop_count", 32'(dut.u_fifo.count_o), FifoDepth - 1);
    go(10'd6, 16'd2, 1);
    chk("odd_wpb", 32'(dut.wpb_q), 2);
    wait_start("odd_start1");
    pop_n(2);
    done_pulse(0);
    wait_start("odd_start2");
    pop_n(2);
    exp_evt.push_back({1'b0, 16'd2});
    done_pulse(0);
    tick();
    chk("odd_buf_wr_en", 32'(bufen), 1);
    // reset in the middle of a block
    go(10'd512, 16'd1, 1);
    wait_start("rst_start");
    pop_n(40);
    rst = 1;
    #1;
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    chk("midrst_count", 32'(dut.u_fifo.count_o), 0);
    chk("midrst_wr_ready", 32'(wready), 1);
    chk("midrst_dat_start", 32'(dstart), 0);
    tick();
    rst = 0;
    exp_data.delete();
    tick();
    // underrun turns a clean done into an error
    go(10'd5, 16'd1, 1);
    write_n(2);
    wait_start("under_start");
    pop_n(3);
    exp_evt.push_back({1'b1, 16'd0});
    done_pulse(0);
    repeat (2) tick();
    // zero count in finite mode is one block
    go(10'd5, 16'd0, 1);
    write_n(2);
    wait_start("zero_start");
    pop_n(2);
    exp_evt.push_back({1'b0, 16'd1});
    done_pulse(0);
    repeat (2) tick();
    chk("zero_idle", 32'(dut.state_q), 32'(IDLE));
    chk("events_drained", exp_evt.size(), 0);
    chk("data_drained", exp_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
